// File: rtl/fp_norm_pkg.sv
// Purpose: shared widths, limits and FSM state type for the half-precision left-normalizer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fp_norm_pkg;

   localparam int EXP_W   = 5;               // biased exponent width (IEEE half)
   localparam int MANT_W  = 11;              // mantissa width incl. hidden bit at MANT_W-1
   localparam int SHIFT_W = $clog2(MANT_W);  // enough bits to count up to MANT_W-1 shifts

   // Smallest biased exponent of a normal number; normalization never goes below it.
   localparam logic [EXP_W-1:0] EXP_MIN_NORMAL = EXP_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      DONE = 2'd2
   } norm_state_t;

endpackage

// File: rtl/controlled_exp_decrementor.sv
// Purpose: select-gated exponent decrement (a - select) as a ripple half-subtractor chain.
// Latency: combinational.
// Backpressure: none; output follows a/select.
//
// Ports:
//   a      in  W   value to decrement
//   select in  1   1: d = a - 1, 0: d = a
//   d      out W   result
//   bout   out 1   borrow out of the MSB (a was 0 while select=1)
module controlled_exp_decrementor #(
   parameter int W = 5
) (
   input  logic [W-1:0] a,
   input  logic         select,
   output logic [W-1:0] d,
   output logic         bout
);

   // Each stage is a half-subtractor: diff = a ^ borrow_in, borrow_out = ~a & borrow_in.
   // The select input is the borrow into bit 0, so select=0 passes a through unchanged.
   always_comb begin
      logic brw;
      brw = select;
      d   = '0;
      for (int i = 0; i < W; i++) begin
         d[i] = a[i] ^ brw;
         brw  = brw & ~a[i];
      end
      bout = brw;
   end

endmodule

// File: rtl/fp_left_normalizer.sv
// Purpose: iterative left-normalizer; shifts mantissa left one bit/clock, decrementing exponent until normalized.
// Latency: out_valid N+1 edges after accept, N = shift_amt (0..MANT_W-1).
// Backpressure: single operand in flight; in_ready only in IDLE; result held in DONE until out_ready.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake; exp_in (biased), mant_in (incl. hidden bit)
//   out_valid/out_ready  result handshake; exp_out, mant_out, shift_amt, zero, subnormal
module fp_left_normalizer
   import fp_norm_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [EXP_W-1:0]   exp_in,
   input  logic [MANT_W-1:0]  mant_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [EXP_W-1:0]   exp_out,
   output logic [MANT_W-1:0]  mant_out,
   output logic [SHIFT_W-1:0] shift_amt,
   output logic               zero,
   output logic               subnormal
);

   norm_state_t        state;
   logic [EXP_W-1:0]   exp_r;
   logic [MANT_W-1:0]  mant_r;
   logic [SHIFT_W-1:0] cnt_r;

   logic               mant_is_zero;
   logic               exp_is_zero;
   logic               hidden_set;
   logic               at_min_normal;
   logic               shift_en;
   logic [EXP_W-1:0]   exp_dec;
   logic               dec_bout;

   assign mant_is_zero  = (mant_r == '0);
   assign exp_is_zero   = (exp_r == '0);
   assign hidden_set    = mant_r[MANT_W-1];
   assign at_min_normal = (exp_r == EXP_MIN_NORMAL);

   // Only a shift step decrements; the termination checks guarantee exp_r >= 2 here.
   assign shift_en = (state == NORM) && !mant_is_zero && !exp_is_zero
                     && !hidden_set && !at_min_normal;

   controlled_exp_decrementor #(
      .W (EXP_W)
   ) u_exp_dec (
      .a      (exp_r),
      .select (shift_en),
      .d      (exp_dec),
      .bout   (dec_bout)
   );

   // A borrow out would mean the exponent wrapped; the termination rules make this unreachable.
   a_no_exp_wrap: assert property (@(posedge clk) disable iff (!rst_n) !dec_bout);

   assign in_ready = (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         exp_r     <= '0;
         mant_r    <= '0;
         cnt_r     <= '0;
         out_valid <= 1'b0;
         exp_out   <= '0;
         mant_out  <= '0;
         shift_amt <= '0;
         zero      <= 1'b0;
         subnormal <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  exp_r  <= exp_in;
                  mant_r <= mant_in;
                  cnt_r  <= '0;
                  state  <= NORM;
               end
            end

            NORM: begin
               // Termination checks in priority order; the first match publishes the result.
               if (mant_is_zero) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  exp_out   <= '0;
                  mant_out  <= '0;
                  shift_amt <= cnt_r;
                  zero      <= 1'b1;
                  subnormal <= 1'b0;
               end else if (exp_is_zero) begin
                  // Already subnormal on entry: pass through unchanged.
                  state     <= DONE;
                  out_valid <= 1'b1;
                  exp_out   <= '0;
                  mant_out  <= mant_r;
                  shift_amt <= cnt_r;
                  zero      <= 1'b0;
                  subnormal <= 1'b1;
               end else if (hidden_set) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  exp_out   <= exp_r;
                  mant_out  <= mant_r;
                  shift_amt <= cnt_r;
                  zero      <= 1'b0;
                  subnormal <= 1'b0;
               end else if (at_min_normal) begin
                  // Hidden bit still clear at minimum exponent: encode as subnormal (exp field 0),
                  // mantissa keeps its current alignment.
                  state     <= DONE;
                  out_valid <= 1'b1;
                  exp_out   <= '0;
                  mant_out  <= mant_r;
                  shift_amt <= cnt_r;
                  zero      <= 1'b0;
                  subnormal <= 1'b1;
               end else begin
                  mant_r <= {mant_r[MANT_W-2:0], 1'b0};
                  exp_r  <= exp_dec;
                  cnt_r  <= cnt_r + SHIFT_W'(1);
               end
            end

            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_left_normalizer.sv
// Purpose: self-checking bench for fp_left_normalizer against a leading-zero-count reference model.
// Latency: checks out_valid arrives shift_amt+1 edges after accept.
// Backpressure: exercises held results, back-to-back operands and reset mid-operation.
module tb_fp_left_normalizer;
   import fp_norm_pkg::*;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic [EXP_W-1:0]   exp_in;
   logic [MANT_W-1:0]  mant_in;
   logic               out_valid;
   logic               out_ready;
   logic [EXP_W-1:0]   exp_out;
   logic [MANT_W-1:0]  mant_out;
   logic [SHIFT_W-1:0] shift_amt;
   logic               zero;
   logic               subnormal;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int                 edges;
      logic [EXP_W-1:0]   e;
      logic [MANT_W-1:0]  m;
      logic [SHIFT_W-1:0] sh;
      logic               z;
      logic               s;
   } obs_t;

   fp_left_normalizer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .exp_in    (exp_in),
      .mant_in   (mant_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .exp_out   (exp_out),
      .mant_out  (mant_out),
      .shift_amt (shift_amt),
      .zero      (zero),
      .subnormal (subnormal)
   );

   always #5 clk = ~clk;

   // Reference: count leading zeros, shift by as many as the exponent allows (down to 1),
   // classify the result. Latency is that shift count plus one.
   function automatic void model(input logic [EXP_W-1:0] ei, input logic [MANT_W-1:0] mi,
                                 output logic [EXP_W-1:0] eo, output logic [MANT_W-1:0] mo,
                                 output logic [SHIFT_W-1:0] sh, output logic z, output logic s);
      int lz, n;
      z = 1'b0; s = 1'b0; eo = '0; mo = mi; sh = '0;
      if (mi == '0) begin
         z  = 1'b1;
         mo = '0;
      end else if (ei == '0) begin
         s = 1'b1;
      end else begin
         lz = 0;
         while (mi[MANT_W-1-lz] == 1'b0) lz++;
         n  = (lz < int'(ei) - 1) ? lz : int'(ei) - 1;
         mo = mi << n;
         sh = SHIFT_W'(n);
         if (lz <= int'(ei) - 1) eo = EXP_W'(int'(ei) - n);
         else begin
            s  = 1'b1;
            eo = '0;
         end
      end
   endfunction

   // Presents one operand when the DUT is ready, then waits (bounded) for out_valid.
   // With noise set, garbage is driven on the input side while the operation is in flight.
   task automatic drive_op(input logic [EXP_W-1:0] e, input logic [MANT_W-1:0] m,
                           input bit noise, output obs_t o);
      bit got_ready;
      o.edges = -1; o.e = 'x; o.m = 'x; o.sh = 'x; o.z = 1'bx; o.s = 1'bx;
      got_ready = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            got_ready = 1'b1;
            break;
         end
      end
      if (!got_ready) return;
      exp_in   = e;
      mant_in  = m;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         if (noise) begin
            in_valid = 1'b1;
            exp_in   = EXP_W'($urandom);
            mant_in  = MANT_W'($urandom);
         end
         @(posedge clk); #1;
         if (out_valid === 1'b1) begin
            o.edges = k;
            break;
         end
      end
      in_valid = 1'b0;
      o.e = exp_out; o.m = mant_out; o.sh = shift_amt; o.z = zero; o.s = subnormal;
   endtask

   task automatic consume();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; exp_in = '0; mant_in = '0;
      #12;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || exp_out !== '0 || mant_out !== '0
          || shift_amt !== '0 || zero !== 1'b0 || subnormal !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: rdy=%b vld=%b exp=%0d mant=%h sh=%0d z=%b s=%b, required rdy=1 rest 0",
                  in_ready, out_valid, exp_out, mant_out, shift_amt, zero, subnormal);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [EXP_W-1:0]   ei [5] = '{5'd15, 5'd15, 5'd20, 5'd3, 5'd0};
      logic [MANT_W-1:0]  mi [5] = '{11'b100_0000_0000, 11'b000_0010_1100, 11'd0,
                                     11'b000_0100_0000, 11'b000_0000_0101};
      logic [EXP_W-1:0]   eo [5] = '{5'd15, 5'd10, 5'd0, 5'd0, 5'd0};
      logic [MANT_W-1:0]  mo [5] = '{11'b100_0000_0000, 11'b101_1000_0000, 11'd0,
                                     11'b001_0000_0000, 11'b000_0000_0101};
      logic [SHIFT_W-1:0] so [5] = '{4'd0, 4'd5, 4'd0, 4'd2, 4'd0};
      logic               zo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic               bo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      int                 lo [5] = '{1, 6, 1, 3, 1};
      obs_t o;
      for (int i = 0; i < 5; i++) begin
         drive_op(ei[i], mi[i], 1'b0, o);
         n_checks++;
         if (o.edges != lo[i] || o.e !== eo[i] || o.m !== mo[i] || o.sh !== so[i]
             || o.z !== zo[i] || o.s !== bo[i]) begin
            n_fail++;
            $display("FAIL directed_%0d: edges=%0d exp=%0d mant=%b sh=%0d z=%b s=%b, required edges=%0d exp=%0d mant=%b sh=%0d z=%b s=%b",
                     i + 1, o.edges, o.e, o.m, o.sh, o.z, o.s, lo[i], eo[i], mo[i], so[i], zo[i], bo[i]);
         end
         consume();
         n_checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL directed_release_%0d: out_valid=%b in_ready=%b, required 0 and 1",
                     i + 1, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_random();
      obs_t o;
      logic [EXP_W-1:0]   e, ee;
      logic [MANT_W-1:0]  m, me;
      logic [SHIFT_W-1:0] se;
      logic               ze, be;
      for (int i = 0; i < 150; i++) begin
         e = ($urandom_range(0, 3) == 0) ? EXP_W'($urandom_range(0, 4)) : EXP_W'($urandom_range(0, 31));
         m = MANT_W'($urandom) >> $urandom_range(0, 11);
         model(e, m, ee, me, se, ze, be);
         drive_op(e, m, ($urandom_range(0, 1) == 1), o);
         n_checks++;
         if (o.edges != int'(se) + 1 || o.e !== ee || o.m !== me || o.sh !== se
             || o.z !== ze || o.s !== be || (o.z === 1'b1 && o.s === 1'b1)) begin
            n_fail++;
            $display("FAIL random_%0d in exp=%0d mant=%b: edges=%0d exp=%0d mant=%b sh=%0d z=%b s=%b, required edges=%0d exp=%0d mant=%b sh=%0d z=%b s=%b",
                     i, e, m, o.edges, o.e, o.m, o.sh, o.z, o.s, int'(se) + 1, ee, me, se, ze, be);
         end
         consume();
      end
   endtask

   task automatic test_backpressure_reset();
      obs_t o;
      drive_op(5'd15, 11'b000_0010_1100, 1'b0, o);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         n_checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || exp_out !== 5'd10
             || mant_out !== 11'b101_1000_0000 || shift_amt !== 4'd5 || zero !== 1'b0 || subnormal !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_cycle_%0d: vld=%b rdy=%b exp=%0d mant=%b sh=%0d z=%b s=%b, required 1 0 10 10110000000 5 0 0",
                     c, out_valid, in_ready, exp_out, mant_out, shift_amt, zero, subnormal);
         end
      end
      consume();
      // New long operation (10 shifts), reset asserted part way through NORM.
      @(negedge clk);
      exp_in = 5'd15; mant_in = 11'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || exp_out !== '0 || mant_out !== '0
          || shift_amt !== '0 || zero !== 1'b0 || subnormal !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_norm: vld=%b rdy=%b exp=%0d mant=%h sh=%0d z=%b s=%b, required vld=0 rdy=1 rest 0",
                  out_valid, in_ready, exp_out, mant_out, shift_amt, zero, subnormal);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive_op(5'd15, 11'd1, 1'b0, o);
      n_checks++;
      if (o.edges != 11 || o.e !== 5'd5 || o.m !== 11'b100_0000_0000 || o.sh !== 4'd10
          || o.z !== 1'b0 || o.s !== 1'b0) begin
         n_fail++;
         $display("FAIL after_reset_max_shift: edges=%0d exp=%0d mant=%b sh=%0d z=%b s=%b, required 11 5 10000000000 10 0 0",
                  o.edges, o.e, o.m, o.sh, o.z, o.s);
      end
      consume();
   endtask

   task automatic test_back_to_back();
      obs_t o;
      logic [EXP_W-1:0]   e, ee;
      logic [MANT_W-1:0]  m, me;
      logic [SHIFT_W-1:0] se;
      logic               ze, be;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         e = EXP_W'($urandom_range(0, 31));
         m = MANT_W'($urandom) >> $urandom_range(0, 11);
         model(e, m, ee, me, se, ze, be);
         drive_op(e, m, 1'b0, o);
         n_checks++;
         if (o.edges != int'(se) + 1 || o.e !== ee || o.m !== me || o.sh !== se || o.z !== ze || o.s !== be) begin
            n_fail++;
            $display("FAIL b2b_%0d in exp=%0d mant=%b: edges=%0d exp=%0d mant=%b sh=%0d, required edges=%0d exp=%0d mant=%b sh=%0d",
                     i, e, m, o.edges, o.e, o.m, o.sh, int'(se) + 1, ee, me, se);
         end
         // Result transfers on the next edge; no operand may be accepted alongside it.
         @(negedge clk);
         n_checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done_%0d: in_ready=%b out_valid=%b, required 0 and 1", i, in_ready, out_valid);
         end
         @(posedge clk); #1;
         n_checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle_%0d: in_ready=%b out_valid=%b, required 1 and 0", i, in_ready, out_valid);
         end
      end
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure_reset();
      test_random();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
